fetch_buffer: RTL
=================

FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning number of entries (power of two, 2..32).
REQ-002 SHALL have ports: clk  in  1  clock; reset  in  1  reset.
REQ-003 SHALL have ports: push_valid  in  1  fetch has an instruction; push_ready  out  1  buffer accepts push.
REQ-004 SHALL have ports: push_pc  in  32 (virt_t)  instruction PC; push_inst  in  32  instruction word; push_exception  in  exception_t  fetch-side exception info.
REQ-005 SHALL have ports: ds_allowin  in  1  decode accepts; fs_to_ds_bus  out  fs_to_ds_bus_t  valid, pc, inst, exception to decode.
REQ-006 SHALL have ports: pipeline_flush  in  pipeline_flush_t  ex/eret/tlb_op/cache_op; redirect  in  1  branch mispredict flush; count  out  $clog2(DEPTH)+1  occupied entries.
REQ-007 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-008 SHALL store entries in FIFO order: circular buffer with rd_ptr, wr_ptr, count.
REQ-009 SHALL complete a push when push_valid && push_ready; a pop when fs_to_ds_bus.valid && ds_allowin.
REQ-010 SHALL drive push_ready = (count < DEPTH) && !flush_any, where flush_any = pipeline_flush.ex|eret|tlb_op|cache_op|redirect.
REQ-011 SHALL drive fs_to_ds_bus.valid = (count != 0) && !flush_any; pc/inst/exception from the head entry.
REQ-012 SHALL, in a cycle with both push and pop, keep count unchanged; both pointers advance.
REQ-013 SHALL wrap pointers modulo DEPTH with no bubble at the wrap point.
REQ-014 SHALL, when full (count == DEPTH), refuse push even if a pop occurs in the same cycle.
REQ-015 SHALL, on flush_any, set count, rd_ptr, wr_ptr to 0 at next edge; no push or pop occurs in the flush cycle.
REQ-016 SHALL pass push_exception unchanged with its instruction, including bd, ex, exccode, badvaddr, tlb_refill.
REQ-017 SHALL, without bypass, have push-to-visible latency of 1 cycle.
REQ-018 SHALL drive count combinationally from the registered occupancy.

Reset
REQ-019 SHALL, on reset, set count=0, rd_ptr=0, wr_ptr=0.
REQ-020 SHALL, during reset, drive fs_to_ds_bus.valid=0 and push_ready=0.
REQ-021 SHALL NOT reset entry storage; it is don't-care while invalid.
REQ-022 SHALL discard all content when reset is asserted mid-operation.

Configuration
REQ-023 SHALL support macro FETCH_BUFFER_BYPASS_EN.
REQ-024 SHALL, with the macro defined, when count==0 && push_valid && !flush_any, present push data on fs_to_ds_bus with valid=1 in the same cycle.
REQ-025 SHALL, with the macro defined, not write the entry if ds_allowin=1 in that cycle; otherwise write it normally.
REQ-026 SHALL, without the macro, never drive fs_to_ds_bus combinationally from push inputs.

Structure
REQ-027 SHALL take fs_to_ds_bus_t, exception_t, pipeline_flush_t, virt_t from the shared cpu package.
REQ-028 SHALL add a fetch_buffer_entry_t typedef (pc, inst, exception) to the shared cpu package.
REQ-029 SHALL be a single module with no sub-module; storage is an array of fetch_buffer_entry_t.

Verification
REQ-030 SHALL test ordering: DEPTH=8, push PCs 0xBFC00000..0xBFC0001C with ds_allowin=0 -> count=8, push_ready=0; then ds_allowin=1 -> pops in the same PC order, one per cycle.
REQ-031 SHALL test simultaneous push/pop: count=3 with push and pop each cycle for 20 cycles -> count stays 3, pointers wrap, order preserved.
REQ-032 SHALL test flush: count=5, assert redirect for 1 cycle with push_valid=1 -> valid=0 and push_ready=0 that cycle; next cycle count=0; the pushed instruction is lost.
REQ-033 SHALL test exception passthrough: push with ex=1, exccode=ADEL, badvaddr=0x00000003 -> identical fields at decode.
REQ-034 SHALL test bypass: empty, push 0x80000000 with ds_allowin=1 -> with macro, valid that cycle and count stays 0; without macro, valid next cycle and count=1.
REQ-035 SHALL test reset mid-operation: count=6, assert reset -> next cycle count=0, valid=0; after release, first push appears as head.

Source files
------------

// File: rtl/fetch_buffer_pkg.sv
// Shared CPU types used by the fetch buffer and its neighbours in the
// front end: virtual address, exception record, pipeline flush bundle,
// fetch-to-decode bus and the fetch buffer entry record.
package fetch_buffer_pkg;

  typedef logic [31:0] virt_t;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;

  typedef struct packed {
    logic       bd;
    logic       ex;
    logic [4:0] exccode;
    virt_t      badvaddr;
    logic       tlb_refill;
  } exception_t;

  typedef struct packed {
    logic ex;
    logic eret;
    logic tlb_op;
    logic cache_op;
  } pipeline_flush_t;

  typedef struct packed {
    logic        valid;
    virt_t       pc;
    logic [31:0] inst;
    exception_t  exception;
  } fs_to_ds_bus_t;

  typedef struct packed {
    virt_t       pc;
    logic [31:0] inst;
    exception_t  exception;
  } fetch_buffer_entry_t;

  // Any of the pipeline flush causes, or a branch redirect, empties the front end.
  function automatic logic flush_any(input pipeline_flush_t pf, input logic redirect);
    return pf.ex | pf.eret | pf.tlb_op | pf.cache_op | redirect;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Fetch buffer: circular FIFO of fetched instructions between the fetch
// stage and decode. Any flush or redirect empties it at the next edge and
// blocks both push and pop in the flush cycle.
// Optional macro FETCH_BUFFER_BYPASS_EN: when the buffer is empty, the
// incoming push is shown to decode in the same cycle; if decode takes it,
// it is never written into storage.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push_valid,
  output logic                    push_ready,
  input  virt_t                   push_pc,
  input  logic [31:0]             push_inst,
  input  exception_t              push_exception,
  input  logic                    ds_allowin,
  output fs_to_ds_bus_t           fs_to_ds_bus,
  input  pipeline_flush_t         pipeline_flush,
  input  logic                    redirect,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_buffer_entry_t r_mem [DEPTH];
  logic [PW-1:0]       r_rd_ptr;
  logic [PW-1:0]       r_wr_ptr;
  logic [CW-1:0]       r_count;

  logic                w_flush_any;
  logic                w_bypass;
  logic                w_valid;
  logic                w_push;
  logic                w_pop;
  logic                w_write;
  logic                w_rd_adv;
  fetch_buffer_entry_t w_head;
  fetch_buffer_entry_t w_push_entry;

  assign w_flush_any = flush_any(pipeline_flush, redirect);

`ifdef FETCH_BUFFER_BYPASS_EN
  assign w_bypass = (r_count == {CW{1'b0}}) && push_valid && !w_flush_any && !reset;
`else
  assign w_bypass = 1'b0;
`endif

  // Full refuses push even when a pop happens in the same cycle.
  assign push_ready = !reset && (r_count < DEPTH_C) && !w_flush_any;
  assign w_valid    = !reset && !w_flush_any && ((r_count != {CW{1'b0}}) || w_bypass);
  assign w_push     = push_valid && push_ready;
  assign w_pop      = w_valid && ds_allowin;
  // A bypassed instruction taken by decode is neither written nor read from storage.
  assign w_write    = w_push && !(w_bypass && ds_allowin);
  assign w_rd_adv   = w_pop && !w_bypass;

  assign w_head       = r_mem[r_rd_ptr];
  assign w_push_entry = '{pc: push_pc, inst: push_inst, exception: push_exception};
  assign count        = r_count;

  // Decode bus: head entry, or the live push when bypassing an empty buffer.
  always_comb begin
    fs_to_ds_bus       = '0;
    fs_to_ds_bus.valid = w_valid;
`ifdef FETCH_BUFFER_BYPASS_EN
    if (w_bypass) begin
      fs_to_ds_bus.pc        = w_push_entry.pc;
      fs_to_ds_bus.inst      = w_push_entry.inst;
      fs_to_ds_bus.exception = w_push_entry.exception;
    end else begin
      fs_to_ds_bus.pc        = w_head.pc;
      fs_to_ds_bus.inst      = w_head.inst;
      fs_to_ds_bus.exception = w_head.exception;
    end
`else
    fs_to_ds_bus.pc        = w_head.pc;
    fs_to_ds_bus.inst      = w_head.inst;
    fs_to_ds_bus.exception = w_head.exception;
`endif
  end

  // Pointer and occupancy bookkeeping; reset and flush both empty the buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= {PW{1'b0}};
      r_wr_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else if (w_flush_any) begin
      r_rd_ptr <= {PW{1'b0}};
      r_wr_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_write) begin
        r_wr_ptr <= r_wr_ptr + {{(PW-1){1'b0}}, 1'b1};
      end
      if (w_rd_adv) begin
        r_rd_ptr <= r_rd_ptr + {{(PW-1){1'b0}}, 1'b1};
      end
      r_count <= r_count + {{PW{1'b0}}, w_write} - {{PW{1'b0}}, w_rd_adv};
    end
  end

  // Entry storage; contents are don't-care while not counted, so no reset.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_wr_ptr] <= w_push_entry;
    end
  end

endmodule
